fa_seq_nb: RTL and testbench

//  Parametrised multi-cycle adder, successor to the fixed 32-bit combinational full adder.

---
 rtl/fa_seq_nb_if.sv | 40 ++++
 rtl/fa_seq_nb.sv | 133 +++++++++++++
 tb/tb_fa_seq_nb.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fa_seq_nb_if.sv
// Request/result bundle for the multi-cycle adder fa_seq_nb.
// Optional subtract select is present only when FA_SUB_EN is defined.
//
// Handshake: start is sampled only while the adder is idle (busy=0). An
// accepted start captures a/b/cin (and sub). busy stays high for the whole
// add. done pulses for exactly one cycle on the edge where sum/cout update.
// start seen while busy=1 is ignored. start in the done cycle is accepted.
interface fa_seq_nb_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef FA_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester side: drives the operands, observes the result.
    modport master (
`ifdef FA_SUB_EN
        output sub,
`endif
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    // Adder side: consumes the operands, produces the result.
    modport slave (
`ifdef FA_SUB_EN
        input  sub,
`endif
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/fa_seq_nb.sv
// fa_seq_nb: parametrised multi-cycle adder. It adds CHUNK bits per clock
// and carries between cycles through a register. The result lands
// NCHUNK = WIDTH/CHUNK cycles after start is accepted.
// Optional feature macro: FA_SUB_EN adds subtraction (a - b) via the sub input.
// WIDTH must be a multiple of CHUNK.
// state_dbg exposes the FSM state: 0 = IDLE, 1 = RUN.
module fa_seq_nb #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic        clk,
    input  logic        rst,
    fa_seq_nb_if.slave  bus,
    output logic        state_dbg
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             finish;

    // Operands shift right one chunk per RUN cycle.
    // The current chunk is therefore always in the low CHUNK bits.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;
    // Chunk results enter at the top and shift down.
    // After NCHUNK steps, every chunk sits in its final position.
    logic [WIDTH-1:0] part_q;

    logic [CHUNK:0]   add_w;
    logic [WIDTH-1:0] part_next;

    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // State register; reset aborts any add in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: accept start in IDLE, finish on the last chunk.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // One chunk of the addition, plus the partial result with that chunk merged in.
    always_comb begin
        add_w     = (CHUNK+1)'(a_q[CHUNK-1:0]) + (CHUNK+1)'(b_q[CHUNK-1:0])
                  + (CHUNK+1)'(carry_q);
        part_next = (part_q >> CHUNK) | (WIDTH'(add_w[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    // Datapath: capture operands on accept, step one chunk per RUN cycle,
    // publish the result on the finishing edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            part_q  <= '0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q   <= bus.a;
                idx_q <= '0;
`ifdef FA_SUB_EN
                // Subtract as a + ~b + 1; cout=1 then means no borrow.
                b_q     <= bus.sub ? ~bus.b : bus.b;
                carry_q <= bus.sub ? 1'b1 : bus.cin;
`else
                b_q     <= bus.b;
                carry_q <= bus.cin;
`endif
            end else if (state == RUN) begin
                a_q     <= a_q >> CHUNK;
                b_q     <= b_q >> CHUNK;
                carry_q <= add_w[CHUNK];
                part_q  <= part_next;
                idx_q   <= idx_q + IDXW'(1);
                if (finish) begin
                    sum_q  <= part_next;
                    cout_q <= add_w[CHUNK];
                    done_q <= 1'b1;
                end
            end
        end
    end

    // busy follows the state directly, so it rises the cycle after accept.
    always_comb begin
        bus.busy  = (state == RUN);
        bus.done  = done_q;
        bus.sum   = sum_q;
        bus.cout  = cout_q;
        state_dbg = state;
    end
endmodule

// File: tb/tb_fa_seq_nb.sv
// Directed bench for fa_seq_nb (WIDTH=32, CHUNK=8).
// Subtraction vectors are included only when FA_SUB_EN is defined.
module tb_fa_seq_nb;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int LAT   = WIDTH / CHUNK;

    logic clk;
    logic rst;
    logic state_dbg;
    int   tests;
    int   fails;
    int   lat;
    int   done_cnt;

    fa_seq_nb_if #(.WIDTH(WIDTH)) bus ();

    fa_seq_nb #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one cycle, then scramble the inputs.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
`ifdef FA_SUB_EN
        bus.sub   = sub;
`else
        if (sub) $display("[TB] sub requested without FA_SUB_EN");
`endif
        tick();
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.cin   = 1'($urandom_range(0, 1));
`ifdef FA_SUB_EN
        bus.sub   = 1'($urandom_range(0, 1));
`endif
    endtask

    // Wait for done with a bound; lat counts cycles after the accept edge.
    task automatic wait_done();
        lat = 0;
        while (!bus.done && lat < 3 * LAT) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_add(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic sub,
                           input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        issue(a, b, cin, sub);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        wait_done();
        chk({tag, "_lat"}, 64'(lat), 64'(LAT));
        chk({tag, "_sum"}, 64'(bus.sum), 64'(exp_sum));
        chk({tag, "_cout"}, 64'(bus.cout), 64'(exp_cout));
    endtask

    // Directed sequence.
    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
`ifdef FA_SUB_EN
        bus.sub   = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_cout", 64'(bus.cout), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'd0);

        // Basic add, then a back-to-back add issued in the done cycle.
        run_add("add1", 32'd1100, 32'd2000, 1'b0, 1'b0, 32'd3100, 1'b0);
        run_add("b2b", 32'd2100, 32'd2500, 1'b1, 1'b0, 32'd4601, 1'b0);
        tick();
        chk("b2b_done_pulse", 64'(bus.done), 64'd0);
        chk("b2b_idle", 64'(bus.busy), 64'd0);
        chk("b2b_hold_sum", 64'(bus.sum), 64'd4601);

        // Carry ripples through all chunks and out of the MSB.
        run_add("ripple", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1);
        run_add("msb_cin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'd1, 1'b1);
        run_add("chunk_cy", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0);

        // A start during RUN is ignored: the original operands win, and only one done pulse occurs.
        issue(32'd10, 32'd20, 1'b0, 1'b0);
        bus.start = 1'b1;
        bus.a     = 32'd7;
        bus.b     = 32'd7;
        tick();
        bus.start = 1'b0;
        chk("ign_hold_sum", 64'(bus.sum), 64'h1_0100_0100 & 64'hFFFF_FFFF);
        lat = 1;
        while (!bus.done && lat < 3 * LAT) begin
            tick();
            lat++;
        end
        chk("ign_lat", 64'(lat), 64'(LAT));
        chk("ign_sum", 64'(bus.sum), 64'd30);
        done_cnt = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        chk("ign_single_done", 64'(done_cnt), 64'd0);
        chk("ign_idle", 64'(bus.busy), 64'd0);

        // Reset two cycles into RUN aborts the add.
        issue(32'd3, 32'd4, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_sum", 64'(bus.sum), 64'd0);
        chk("abort_cout", 64'(bus.cout), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'd0);

        // The adder works again after the abort.
        run_add("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0);

`ifdef FA_SUB_EN
        run_add("sub_pos", 32'd5000, 32'd1200, 1'b0, 1'b1, 32'd3800, 1'b1);
        run_add("sub_neg", 32'd5, 32'd9, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        run_add("sub_off", 32'd5, 32'd9, 1'b1, 1'b0, 32'd15, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
